id_decode_regfile: RTL and testbench

Combinational MIPS-I instruction decoder, next-instruction-address calculator and 32×32 register file, packaged as the core of the ID stage. The block turns a fetched instruction into control flags, a jump/branch target and up to three register read values. The surrounding ID logic adds forwarding, pipeline registers and branch comparison.

---
 rtl/id_decode_regfile.sv | 110 +++++++++++
 tb/tb_id_decode_regfile.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_decode_regfile.sv
// ID-stage core: MIPS-I control decode, jump/branch target and 32x32 register file.
// Reads are combinational with no write bypass; the caller handles forwarding.
module id_decode_regfile (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] Instr_PC_Plus4,
  input  logic [31:0] JumpRegValue,
  input  logic [4:0]  RegC,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic        Write,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  output logic [31:0] DataC,
  output logic        Link,
  output logic        RegDest,
  output logic        Jump,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        JumpRegister,
  output logic        SignOrZero,
  output logic        Syscall,
  output logic [5:0]  ALUControl,
  output logic [31:0] NextInstructionAddress
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic [31:0] regs_q [32];

  assign op    = Instr[31:26];
  assign rs    = Instr[25:21];
  assign rt    = Instr[20:16];
  assign funct = Instr[5:0];

  assign ALUControl = (op == 6'h00) ? funct : op;

  always_comb begin
    Link = 1'b0; RegDest = 1'b0; Jump = 1'b0; Branch = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; ALUSrc = 1'b0; RegWrite = 1'b0;
    JumpRegister = 1'b0; SignOrZero = 1'b0; Syscall = 1'b0;
    case (op)
      6'h00: begin
        // only recognised MIPS-I SPECIAL functs assert anything
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0D,
          6'h10, 6'h11, 6'h12, 6'h13,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            RegDest = 1'b1; RegWrite = 1'b1;
          end
          6'h08: begin RegDest = 1'b1; Jump = 1'b1; JumpRegister = 1'b1; end
          6'h09: begin
            RegDest = 1'b1; RegWrite = 1'b1; Jump = 1'b1; JumpRegister = 1'b1; Link = 1'b1;
          end
          6'h0C: begin RegDest = 1'b1; Syscall = 1'b1; end
          6'h18, 6'h19, 6'h1A, 6'h1B: RegDest = 1'b1;
          default: ;
        endcase
      end
      6'h01: begin
        Branch = 1'b1;
        if (rt == 5'd16 || rt == 5'd17) begin Link = 1'b1; RegWrite = 1'b1; end
      end
      6'h02: Jump = 1'b1;
      6'h03: begin Jump = 1'b1; Link = 1'b1; RegWrite = 1'b1; end
      6'h04, 6'h05, 6'h06, 6'h07: Branch = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B: begin ALUSrc = 1'b1; RegWrite = 1'b1; SignOrZero = 1'b1; end
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin ALUSrc = 1'b1; RegWrite = 1'b1; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        MemRead = 1'b1; RegWrite = 1'b1; ALUSrc = 1'b1; SignOrZero = 1'b1;
      end
      // LL/SC raise Syscall so the pipeline flushes the cache around them
      6'h30: begin
        MemRead = 1'b1; RegWrite = 1'b1; ALUSrc = 1'b1; SignOrZero = 1'b1; Syscall = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin MemWrite = 1'b1; ALUSrc = 1'b1; SignOrZero = 1'b1; end
      6'h38: begin
        MemWrite = 1'b1; ALUSrc = 1'b1; SignOrZero = 1'b1; RegWrite = 1'b1; Syscall = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (Jump && JumpRegister)
      NextInstructionAddress = JumpRegValue;
    else if (Jump)
      NextInstructionAddress = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
    else
      NextInstructionAddress = Instr_PC_Plus4 + {{14{Instr[15]}}, Instr[15:0], 2'b00};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (Write && WriteReg != 5'd0) begin
      regs_q[WriteReg] <= WriteData;
    end
  end

  assign DataA = (rs   == 5'd0) ? 32'd0 : regs_q[rs];
  assign DataB = (rt   == 5'd0) ? 32'd0 : regs_q[rt];
  assign DataC = (RegC == 5'd0) ? 32'd0 : regs_q[RegC];

endmodule

// File: tb/tb_id_decode_regfile.sv
// Bench for id_decode_regfile: spec-level model checked every cycle plus literal pins.
module tb_id_decode_regfile;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic [31:0] Instr = 32'h0, Instr_PC_Plus4 = 32'h0, JumpRegValue = 32'h0;
  logic [4:0]  RegC = 5'd0, WriteReg = 5'd0;
  logic [31:0] WriteData = 32'h0;
  logic        Write = 1'b0;
  logic [31:0] DataA, DataB, DataC, NextInstructionAddress;
  logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite;
  logic        JumpRegister, SignOrZero, Syscall;
  logic [5:0]  ALUControl;

  id_decode_regfile dut (
    .CLK(CLK), .RESET(RESET), .Instr(Instr), .Instr_PC_Plus4(Instr_PC_Plus4),
    .JumpRegValue(JumpRegValue), .RegC(RegC), .WriteReg(WriteReg),
    .WriteData(WriteData), .Write(Write), .DataA(DataA), .DataB(DataB), .DataC(DataC),
    .Link(Link), .RegDest(RegDest), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .JumpRegister(JumpRegister), .SignOrZero(SignOrZero), .Syscall(Syscall),
    .ALUControl(ALUControl), .NextInstructionAddress(NextInstructionAddress)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  bit en_cmp = 1'b0;
  logic [31:0] mregs [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Flag order: Link RegDest Jump Branch MemRead MemWrite ALUSrc RegWrite JumpRegister SignOrZero Syscall
  localparam int LNK = 10, RDS = 9, JMP = 8, BRN = 7, MRD = 6, MWR = 5,
                 ASR = 4, RWR = 3, JRG = 2, SOZ = 1, SYS = 0;

  function automatic logic [10:0] model_flags(input logic [31:0] ins);
    logic [10:0] f = '0;
    int op = ins[31:26], fn = ins[5:0], rt = ins[20:16];
    if (op == 0) begin
      if (fn inside {0, 2, 3, 4, 6, 7, 8, 9, 12, 13, [16:19], [24:27], [32:39], 42, 43}) begin
        f[RDS] = 1; f[RWR] = 1;
        if (fn == 8 || fn == 9) begin f[JMP] = 1; f[JRG] = 1; end
        if (fn == 9) f[LNK] = 1;
        if (fn inside {8, 12, [24:27]}) f[RWR] = 0;
        if (fn == 12) f[SYS] = 1;
      end
    end else if (op inside {2, 3}) begin
      f[JMP] = 1;
      if (op == 3) begin f[LNK] = 1; f[RWR] = 1; end
    end else if (op inside {[1:7]}) begin
      f[BRN] = 1;
      if (op == 1 && rt inside {16, 17}) begin f[LNK] = 1; f[RWR] = 1; end
    end else if (op inside {[8:15]}) begin
      f[ASR] = 1; f[RWR] = 1; f[SOZ] = (op <= 11);
    end else if (op inside {32, 33, 35, 36, 37, 48}) begin
      f[MRD] = 1; f[RWR] = 1; f[ASR] = 1; f[SOZ] = 1; f[SYS] = (op == 48);
    end else if (op inside {40, 41, 43, 56}) begin
      f[MWR] = 1; f[ASR] = 1; f[SOZ] = 1;
      if (op == 56) begin f[RWR] = 1; f[SYS] = 1; end
    end
    return f;
  endfunction

  function automatic logic [31:0] model_nia(input logic [31:0] ins, input logic [31:0] pc4,
                                            input logic [31:0] jrv, input logic [10:0] f);
    if (f[JMP] && f[JRG]) return jrv;
    if (f[JMP]) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    return pc4 + 32'(int'($signed(ins[15:0])) * 4);
  endfunction

  function automatic logic [31:0] rd(input logic [4:0] a);
    return (a == 0) ? 32'd0 : mregs[a];
  endfunction

  always @(negedge RESET) for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
  always @(posedge CLK) if (RESET === 1'b1 && Write && WriteReg != 0) mregs[WriteReg] = WriteData;

  logic [10:0] dut_flags;
  assign dut_flags = {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite,
                      JumpRegister, SignOrZero, Syscall};

  always @(negedge CLK) if (en_cmp) begin
    logic [10:0] ef;
    ef = model_flags(Instr);
    check("cyc_flags", {21'd0, dut_flags}, {21'd0, ef});
    check("cyc_aluctl", {26'd0, ALUControl}, {26'd0, (Instr[31:26] == 0) ? Instr[5:0] : Instr[31:26]});
    check("cyc_nia", NextInstructionAddress, model_nia(Instr, Instr_PC_Plus4, JumpRegValue, ef));
    check("cyc_dataA", DataA, rd(Instr[25:21]));
    check("cyc_dataB", DataB, rd(Instr[20:16]));
    check("cyc_dataC", DataC, rd(RegC));
  end

  task automatic step(); @(posedge CLK); #1; endtask
  task automatic mid();  @(negedge CLK); #1; endtask

  typedef struct { logic [31:0] ins; logic [4:0] rc; } vec_t;
  vec_t sweep [10];

  initial begin
    #3 RESET = 1'b0;
    en_cmp = 1'b1;
    step(); step(); RESET = 1'b1;
    Instr = 32'h00A0_0000;  // rs=5
    mid(); check("reset_r5", DataA, 32'h0);

    step(); Write = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEAD_BEEF;
    mid(); check("wr_cycle_old", DataA, 32'h0);
    step(); Write = 1'b0;
    mid(); check("wr_r5_new", DataA, 32'hDEAD_BEEF);

    step(); Instr = 32'h0000_0000; Write = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234;
    step(); Write = 1'b0;
    mid(); check("r0_zero", DataA, 32'h0);

    for (int i = 1; i < 32; i++) begin
      step(); Write = 1'b1; WriteReg = 5'(i); WriteData = 32'h1000_0000 * 32'(i % 8) + 32'(i * 3);
    end
    step(); Write = 1'b0;

    step(); Instr = 32'h2508_FFFF; Instr_PC_Plus4 = 32'h0040_0000; RegC = 5'd9;
    mid(); check("addiu_alusrc", {31'd0, ALUSrc}, 1); check("addiu_rw", {31'd0, RegWrite}, 1);
    check("addiu_soz", {31'd0, SignOrZero}, 1); check("addiu_rd", {31'd0, RegDest}, 0);
    check("addiu_alu", {26'd0, ALUControl}, 32'h09);

    step(); Instr = 32'h0109_5021;
    mid(); check("addu_rd", {31'd0, RegDest}, 1); check("addu_rw", {31'd0, RegWrite}, 1);
    check("addu_alu", {26'd0, ALUControl}, 32'h21);

    step(); Instr = 32'h03E0_0008; JumpRegValue = 32'h0040_0100;
    mid(); check("jr_jump", {31'd0, Jump}, 1); check("jr_jreg", {31'd0, JumpRegister}, 1);
    check("jr_rw", {31'd0, RegWrite}, 0); check("jr_nia", NextInstructionAddress, 32'h0040_0100);

    step(); Instr = 32'h0810_0040; Instr_PC_Plus4 = 32'h0040_0008;
    mid(); check("j_nia", NextInstructionAddress, 32'h0040_0100);

    step(); Instr = 32'h1000_FFFF; Instr_PC_Plus4 = 32'h0040_0010;
    mid(); check("beq_br", {31'd0, Branch}, 1); check("beq_nia", NextInstructionAddress, 32'h0040_000C);

    step(); Instr = 32'h0000_000C;
    mid(); check("sys_sys", {31'd0, Syscall}, 1); check("sys_rw", {31'd0, RegWrite}, 0);

    step(); Instr = 32'hC000_0000;
    mid(); check("ll_sys", {31'd0, Syscall}, 1); check("ll_mrd", {31'd0, MemRead}, 1);

    step(); Instr = 32'hE000_0000;
    mid(); check("sc_sys", {31'd0, Syscall}, 1); check("sc_mwr", {31'd0, MemWrite}, 1);
    check("sc_rw", {31'd0, RegWrite}, 1);

    step(); Instr = 32'h0411_0010;
    mid(); check("bgezal_br", {31'd0, Branch}, 1); check("bgezal_lnk", {31'd0, Link}, 1);
    check("bgezal_rw", {31'd0, RegWrite}, 1);

    step(); Instr = 32'hFC00_0000;
    mid(); check("undef_flags", {21'd0, dut_flags}, 32'h0);

    sweep = '{'{32'h0C10_0020, 5'd3}, '{32'h0221_F809, 5'd7}, '{32'h8C43_0004, 5'd31},
              '{32'hAC43_FFF8, 5'd4}, '{32'h3C01_1234, 5'd0}, '{32'h3421_00FF, 5'd12},
              '{32'h1C80_7FFF, 5'd2}, '{32'h0001_0018, 5'd6}, '{32'h0400_8000, 5'd17},
              '{32'h0000_003F, 5'd1}};
    for (int i = 0; i < 10; i++) begin
      step(); Instr = sweep[i].ins; RegC = sweep[i].rc;
      Instr_PC_Plus4 = 32'h8000_0000 + 32'(i * 16); JumpRegValue = 32'h00C0_0000 + 32'(i);
    end

    step(); Instr = 32'h00A0_0000; RESET = 1'b0;
    mid(); check("midreset_r5", DataA, 32'h0);
    step(); Write = 1'b1; WriteReg = 5'd5; WriteData = 32'h5555_5555;
    mid(); step(); Write = 1'b0;
    mid(); check("wr_blocked", DataA, 32'h0);
    RESET = 1'b1;
    step(); mid();
    en_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
